// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, flag bit positions and FSM states for the multiplier request driver
package mult_pkg;
  localparam int OP_W = 16;
  localparam int RES_W = 32;
  localparam int FLAG_W = 3;
  localparam int FLAG_TO = 2;
  localparam int FLAG_APE = 1;
  localparam int FLAG_RPE = 0;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RDY, OUT} state_t;
endpackage

// File: rtl/mult_timeout_cnt.sv
// mult_timeout_cnt: cycle counter that flags expiry after TIMEOUT enabled cycles
module mult_timeout_cnt #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] cnt;
  // count enabled cycles; the last counted cycle raises expired
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign expired = en && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/mult_req_driver.sv
// mult_req_driver: drives one multiplier request per operand pair and returns the product; MULT_DRV_PAR_INJECT_EN adds parity-inversion inputs
import mult_pkg::*;
module mult_req_driver #(
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MULT_DRV_PAR_INJECT_EN
  input  logic              inj_a,
  input  logic              inj_b,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_arg_a,
  input  logic [OP_W-1:0]   in_arg_b,
  output logic              req,
  output logic [OP_W-1:0]   arg_a,
  output logic [OP_W-1:0]   arg_b,
  output logic              arg_a_parity,
  output logic              arg_b_parity,
  input  logic              ack,
  input  logic [RES_W-1:0]  result,
  input  logic              result_parity,
  input  logic              result_rdy,
  input  logic              arg_parity_error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic [FLAG_W-1:0] out_flags
);
  state_t state, state_n;
  logic cap, tmo, expired, ia, ib;
`ifdef MULT_DRV_PAR_INJECT_EN
  assign ia = inj_a;
  assign ib = inj_b;
`else
  assign ia = 1'b0;
  assign ib = 1'b0;
`endif
  assign in_ready = state == IDLE;
  assign req = state == REQ;
  assign out_valid = state == OUT;
  mult_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clear(state == IDLE),
    .en(state == REQ || state == WAIT_RDY),
    .expired(expired)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: a response wins over expiry, expiry wins over a bare ack
  always_comb begin
    cap = result_rdy && ((state == REQ && ack) || state == WAIT_RDY);
    tmo = expired && !cap;
    state_n = cap || tmo ? OUT :
              state == IDLE && in_valid ? REQ :
              state == REQ && ack ? WAIT_RDY :
              state == OUT && out_ready ? IDLE : state;
  end
  // operand capture on accept, product/flag capture on response or timeout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      arg_a <= '0;
      arg_b <= '0;
      arg_a_parity <= 1'b0;
      arg_b_parity <= 1'b0;
      out_result <= '0;
      out_flags <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        arg_a <= in_arg_a;
        arg_b <= in_arg_b;
        arg_a_parity <= ^in_arg_a ^ ia;
        arg_b_parity <= ^in_arg_b ^ ib;
      end
      if (cap) begin
        out_result <= result;
        out_flags <= '0;
        out_flags[FLAG_APE] <= arg_parity_error;
        out_flags[FLAG_RPE] <= ^result != result_parity;
      end else if (tmo) begin
        out_result <= '0;
        out_flags <= '0;
        out_flags[FLAG_TO] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_mult_req_driver.sv
// tb_mult_req_driver: scoreboard bench for mult_req_driver
module tb_mult_req_driver;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [15:0] in_arg_a = '0, in_arg_b = '0;
  logic req, arg_a_parity, arg_b_parity;
  logic [15:0] arg_a, arg_b;
  logic ack = 1'b0, result_parity = 1'b0, result_rdy = 1'b0, arg_parity_error = 1'b0;
  logic [31:0] result = '0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] out_result;
  logic [2:0] out_flags;
  logic inj_a_v = 1'b0, inj_b_v = 1'b0;
  int tests = 0, fails = 0;
  typedef struct packed {logic [31:0] r; logic [2:0] f;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mult_req_driver #(.TIMEOUT(1023)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MULT_DRV_PAR_INJECT_EN
    .inj_a(inj_a_v),
    .inj_b(inj_b_v),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_arg_a(in_arg_a),
    .in_arg_b(in_arg_b),
    .req(req),
    .arg_a(arg_a),
    .arg_b(arg_b),
    .arg_a_parity(arg_a_parity),
    .arg_b_parity(arg_b_parity),
    .ack(ack),
    .result(result),
    .result_parity(result_parity),
    .result_rdy(result_rdy),
    .arg_parity_error(arg_parity_error),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_flags(out_flags)
  );

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    in_arg_a = a;
    in_arg_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_arg_a = 16'h5a5a;
    in_arg_b = 16'ha5a4;
    tests++;
    if (req !== 1'b1 || in_ready !== 1'b0 || arg_a !== a || arg_b !== b) begin
      fails++;
      $display("FAIL send: req=%b in_ready=%b arg_a=%h arg_b=%h required req=1 in_ready=0 %h %h", req, in_ready, arg_a, arg_b, a, b);
    end
    tests++;
    if (arg_a_parity !== (^a ^ inj_a_v) || arg_b_parity !== (^b ^ inj_b_v)) begin
      fails++;
      $display("FAIL parity: got %b%b required %b%b", arg_a_parity, arg_b_parity, ^a ^ inj_a_v, ^b ^ inj_b_v);
    end
  endtask

  task automatic reply(input int dly, input bit same, input logic [31:0] r, input bit rp, input bit ape);
    repeat (dly) @(negedge clk);
    ack = 1'b1;
    result = r;
    result_parity = rp;
    arg_parity_error = ape;
    result_rdy = same;
    sb.push_back('{r: r, f: {1'b0, ape, (^r) ^ rp}});
    @(negedge clk);
    ack = 1'b0;
    if (!same) begin
      tests++;
      if (req !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL wait_state: req=%b out_valid=%b required 0 0", req, out_valid);
      end
      result_rdy = 1'b1;
      @(negedge clk);
    end
    result_rdy = 1'b0;
    arg_parity_error = 1'b0;
    result = 32'hdead_beef;
  endtask

  task automatic collect(input int hold, input int budget);
    exp_t e;
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      fails++;
      $display("FAIL out_valid_wait: out_valid=%b queued=%0d after %0d cycles", out_valid, sb.size(), n);
      return;
    end
    e = sb.pop_front();
    tests++;
    if (out_result !== e.r || out_flags !== e.f) begin
      fails++;
      $display("FAIL result: got %h/%b required %h/%b", out_result, out_flags, e.r, e.f);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== e.r || out_flags !== e.f) begin
        fails++;
        $display("FAIL hold%0d: out_valid=%b in_ready=%b %h/%b required 1 0 %h/%b", i, out_valid, in_ready, out_result, out_flags, e.r, e.f);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (req !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'd0 || out_flags !== 3'd0 ||
        arg_a !== 16'd0 || arg_b !== 16'd0 || arg_a_parity !== 1'b0 || arg_b_parity !== 1'b0) begin
      fails++;
      $display("FAIL reset: req=%b ov=%b res=%h fl=%b a=%h b=%h pa=%b pb=%b required all 0",
               req, out_valid, out_result, out_flags, arg_a, arg_b, arg_a_parity, arg_b_parity);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL in_ready_after_reset: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    send(16'd3, 16'hfffe);
    tests++;
    if (arg_a_parity !== 1'b0 || arg_b_parity !== 1'b1) begin
      fails++;
      $display("FAIL basic_parity: got %b%b required 01", arg_a_parity, arg_b_parity);
    end
    reply(2, 0, 32'hffff_fffa, 0, 0);
    tests++;
    if (sb.size() != 1 || sb[0].f !== 3'b000) begin
      fails++;
      $display("FAIL basic_expect: queued=%0d required 1 entry flags 000", sb.size());
    end
    collect(0, 4);
  endtask

  task automatic test_result_parity();
    send(16'd3, 16'hfffe);
    reply(0, 0, 32'hffff_fffa, 1, 0);
    collect(0, 4);
  endtask

  task automatic test_same_cycle();
    send(16'hfff9, 16'd9);
    reply(1, 1, 32'hffff_ffc1, 0, 0);
    collect(0, 4);
  endtask

  task automatic test_timeout();
    int n = 0;
    send(16'd7, 16'd11);
    sb.push_back('{r: 32'd0, f: 3'b100});
    while (req && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 1023) begin
      fails++;
      $display("FAIL timeout_len: req high %0d cycles required 1023", n);
    end
    collect(0, 2);
  endtask

  task automatic test_backpressure();
    send(16'd100, 16'hff9c);
    reply(0, 0, 32'hffff_d8f0, 0, 1);
    collect(5, 4);
  endtask

  task automatic test_ignore();
    ack = 1'b1;
    result_rdy = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || req !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL ignore_idle: in_ready=%b req=%b ov=%b required 1 0 0", in_ready, req, out_valid);
    end
    ack = 1'b0;
    send(16'd4, 16'd6);
    repeat (2) @(negedge clk);
    tests++;
    if (req !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL ignore_rdy_in_req: req=%b ov=%b required 1 0", req, out_valid);
    end
    result_rdy = 1'b0;
    reply(0, 0, 32'd24, 0, 0);
    collect(0, 4);
  endtask

  task automatic test_reset_mid();
    send(16'd9, 16'd9);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || arg_a !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid: req=%b ov=%b in_ready=%b arg_a=%h required 0 0 1 0", req, out_valid, in_ready, arg_a);
    end
    @(negedge clk);
    rst = 1'b0;
    result_rdy = 1'b1;
    @(negedge clk);
    result_rdy = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_no_result: ov=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    send(16'd2, 16'd5);
    reply(0, 0, 32'd10, 0, 0);
    collect(0, 4);
  endtask

`ifdef MULT_DRV_PAR_INJECT_EN
  task automatic test_inject();
    inj_a_v = 1'b1;
    send(16'd1, 16'd4);
    inj_a_v = 1'b0;
    tests++;
    if (arg_a_parity !== 1'b0) begin
      fails++;
      $display("FAIL inject_parity: got %b required 0", arg_a_parity);
    end
    reply(0, 0, 32'd4, 1, 1);
    collect(0, 4);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_result_parity();
    test_same_cycle();
    test_ignore();
    test_backpressure();
    test_timeout();
    test_reset_mid();
`ifdef MULT_DRV_PAR_INJECT_EN
    test_inject();
`endif
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mult_req_driver.md
MULT_REQ_DRIVER -- requirements
Module: mult_req_driver

Interface
REQ-001 Parameter TIMEOUT, default 1023: max cycles to wait for ack or result_rdy before abort.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  operand pair offered.
REQ-005 in_ready  out  1  driver can accept operand pair.
REQ-006 in_arg_a, in_arg_b  in  16 each  signed operands.
REQ-007 req  out  1  multiplier request.
REQ-008 arg_a, arg_b  out  16 each  signed operands to multiplier.
REQ-009 arg_a_parity, arg_b_parity  out  1 each  operand parity bits.
REQ-010 ack  in  1  multiplier accepted request.
REQ-011 result  in  32  signed product.
REQ-012 result_parity  in  1  product parity.
REQ-013 result_rdy  in  1  product valid.
REQ-014 arg_parity_error  in  1  multiplier detected operand parity error.
REQ-015 out_valid  out  1; out_ready  in  1: result stream handshake.
REQ-016 out_result  out  32  captured signed product.
REQ-017 out_flags  out  3  {timeout, arg_parity_error, result_parity_error}.

Function
REQ-018 FSM states IDLE, REQ, WAIT_RDY, OUT; in_ready=1 only in IDLE; req=1 only in REQ; out_valid=1 only in OUT.
REQ-019 IDLE: on in_valid&&in_ready, register operands, parity = XOR-reduce of each operand, go REQ (req high next cycle).
REQ-020 arg_a/arg_b/parity outputs held stable from REQ entry until return to IDLE.
REQ-021 REQ: on ack sampled high, go WAIT_RDY (req low next cycle); if ack and result_rdy both high same cycle, capture and go OUT directly.
REQ-022 WAIT_RDY: on result_rdy sampled high, capture result into out_result, flags[1]=arg_parity_error, flags[0]=(^result != result_parity), flags[2]=0, go OUT.
REQ-023 Latency: out_valid asserts the cycle after result_rdy is sampled.
REQ-024 Timeout counter cleared on entering REQ, counts in REQ and WAIT_RDY; reaching TIMEOUT: out_result=0, out_flags=3'b100, go OUT.
REQ-025 OUT: out_result/out_flags stable while out_valid && !out_ready; on out_ready go IDLE; no back-to-back accept in same cycle.
REQ-026 ack or result_rdy outside the state that samples it is ignored.

Reset
REQ-027 While rst high: state IDLE, req=0, out_valid=0, out_result=0, out_flags=0, arg_a/arg_b/parities=0, counter=0; in_ready=1 after release.
REQ-028 Reset mid-transaction aborts immediately (asynchronous); no partial result is emitted.

Configuration
REQ-029 Macro MULT_DRV_PAR_INJECT_EN defined: adds inputs inj_a, inj_b (1 bit each), sampled with operands; when set, the corresponding generated parity bit is inverted.
REQ-030 Macro undefined: ports inj_a/inj_b absent; parity always correct.

Structure
REQ-031 mult_pkg holds the FSM state enum, flag bit-index constants, operand/result width constants.
REQ-032 One sub-module, mult_timeout_cnt: clear/enable/expired, width derived from TIMEOUT.

Verification
REQ-033 a=3, b=-2; responder returns result=-6 (0xFFFFFFFA), parity 0 -> arg_a_parity=0, arg_b_parity=1, out_result=-6, out_flags=3'b000.
REQ-034 Same operands, responder returns result_parity=1 -> out_flags=3'b001.
REQ-035 ack held low -> req stays high TIMEOUT cycles, then out_valid with out_result=0, out_flags=3'b100.
REQ-036 out_ready low 5 cycles after result -> out_valid held, out_result stable, in_ready=0; completes on out_ready.
REQ-037 rst pulsed during WAIT_RDY -> req=0, out_valid=0 immediately; next transaction a=2, b=5 yields out_result=10.
REQ-038 Macro defined, a=1, inj_a=1 -> arg_a_parity=0; responder asserts arg_parity_error -> out_flags=3'b010.
